// File: rtl/bp_pkg.sv
// Shared types for the branch resolver slice.
//   pred_entry_t : one fetch-side prediction, kept in fetch order until ID resolves it
//   upd_cmd_t    : one BTB / 2-bit-counter update sent back to the predictor
//   BTB_IDX_W    : number of low PC bits the predictor uses to index its BTB
package bp_pkg;

  localparam int BTB_IDX_W = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;   // 1: increment counter, 0: decrement
    logic        alloc;   // 1: write a fresh BTB entry, counter set to weakly taken
  } upd_cmd_t;

  // BTB index the predictor derives from an update PC.
  function automatic logic [BTB_IDX_W-1:0] btb_idx(input logic [31:0] pc);
    return pc[BTB_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/bp_sync_fifo.sv
// Small synchronous FIFO with a single-cycle clear, used both for the
// in-flight prediction queue and for the predictor update FIFO.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   clear           empties the FIFO at the next edge; beats any write that edge
//   wr_en, wr_data  enqueue request; honoured when not full (or full with a pop)
//   rd_en           dequeue request; honoured when not empty
//   rd_data         current head entry (valid when !empty)
//   full, empty     occupancy flags
module bp_sync_fifo
  import bp_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A pop in the same edge frees the slot, so a full FIFO may still accept.
  assign do_wr   = wr_en && (!full || do_rd) && !clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are log2(DEPTH) bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Decode-stage branch resolver. Records every fetch prediction in order,
// checks it against the outcome resolved in ID, flushes and redirects on a
// mispredict, and sends BTB / counter updates back to the predictor.
//
// Handshakes (all three ports): a transfer happens on a rising edge where
// valid && ready are both high; ready never depends on valid, and a producer
// holds its payload stable while valid && !ready.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   f_valid/f_ready, f_pc,
//   f_pred_taken, f_pred_target        prediction push from fetch
//   d_valid/d_ready, d_is_branch,
//   d_taken, d_target                  resolution from ID (pops queue head)
//   flush, redirect_pc                 one-cycle registered kill + correct next PC
//   upd_valid/upd_ready, upd_pc,
//   upd_target, upd_taken, upd_alloc   update command to the predictor
//   mispredicts                        saturating mispredict count
module branch_resolver
  import bp_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int UDEPTH = 2,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            f_valid,
  input  logic [31:0]     f_pc,
  input  logic            f_pred_taken,
  input  logic [31:0]     f_pred_target,
  output logic            f_ready,
  input  logic            d_valid,
  input  logic            d_is_branch,
  input  logic            d_taken,
  input  logic [31:0]     d_target,
  output logic            d_ready,
  output logic            flush,
  output logic [31:0]     redirect_pc,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [31:0]     upd_pc,
  output logic [31:0]     upd_target,
  output logic            upd_taken,
  output logic            upd_alloc,
  output logic [CNTW-1:0] mispredicts
);

  pred_entry_t q_in;
  pred_entry_t q_head;
  logic        q_full;
  logic        q_empty;
  logic        q_push;
  upd_cmd_t    u_in;
  upd_cmd_t    u_head;
  logic        u_full;
  logic        u_empty;

  logic        resolve;
  logic        mispredict;
  logic        misp_now;
  logic        upd_emit;
  logic [31:0] redirect_next;
  logic [31:0] pc_plus4;

  assign f_ready = !q_full;
  assign d_ready = !q_empty && !u_full;
  assign resolve = d_valid && d_ready;
  // Fetch-side instructions arriving during the flush cycle are wrong-path.
  assign q_push  = f_valid && f_ready && !flush;
  assign q_in    = '{pc: f_pc, pred_taken: f_pred_taken, pred_target: f_pred_target};

  bp_sync_fifo #(
    .W     ($bits(pred_entry_t)),
    .DEPTH (QDEPTH)
  ) u_pred_q (
    .clk     (clk),
    .reset   (reset),
    .clear   (misp_now),
    .wr_en   (q_push),
    .wr_data (q_in),
    .rd_en   (resolve),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  // 32-bit modulo add: the fall-through of 0xFFFFFFFC is 0.
  assign pc_plus4 = q_head.pc + 32'd4;

  // Outcome vs prediction. For not-taken updates the target is unused by the
  // predictor; the predicted target is passed along unchanged.
  always_comb begin
    mispredict    = 1'b0;
    upd_emit      = 1'b0;
    redirect_next = d_target;
    u_in          = '{pc: q_head.pc, target: q_head.pred_target, taken: 1'b0, alloc: 1'b0};
    if (d_is_branch) begin
      if (d_taken) begin
        upd_emit     = 1'b1;
        u_in.taken   = 1'b1;
        u_in.target  = d_target;
        // Missing prediction or wrong target both need a fresh BTB entry.
        if (!q_head.pred_taken || (d_target != q_head.pred_target)) begin
          mispredict    = 1'b1;
          u_in.alloc    = 1'b1;
          redirect_next = d_target;
        end
      end else if (q_head.pred_taken) begin
        mispredict    = 1'b1;
        upd_emit      = 1'b1;
        redirect_next = pc_plus4;
      end
      // Not taken and not predicted: nothing in the BTB to train.
    end else if (q_head.pred_taken) begin
      // A non-branch hit an aliased BTB entry: weaken it and fall through.
      mispredict    = 1'b1;
      upd_emit      = 1'b1;
      redirect_next = pc_plus4;
    end
  end

  assign misp_now = resolve && mispredict;

  bp_sync_fifo #(
    .W     ($bits(upd_cmd_t)),
    .DEPTH (UDEPTH)
  ) u_upd_q (
    .clk     (clk),
    .reset   (reset),
    .clear   (1'b0),
    .wr_en   (resolve && upd_emit),
    .wr_data (u_in),
    .rd_en   (upd_valid && upd_ready),
    .rd_data (u_head),
    .full    (u_full),
    .empty   (u_empty)
  );

  assign upd_valid  = !u_empty;
  assign upd_pc     = u_head.pc;
  assign upd_target = u_head.target;
  assign upd_taken  = u_head.taken;
  assign upd_alloc  = u_head.alloc;

  // flush is a one-cycle pulse: the queue is cleared on the same edge, so
  // d_ready is low during the flush cycle and no back-to-back mispredict can occur.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      mispredicts <= '0;
    end else begin
      flush <= misp_now;
      if (misp_now) begin
        redirect_pc <= redirect_next;
        if (mispredicts != '1) begin
          mispredicts <= mispredicts + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver: linear stimulus, immediate
// assertions at each check, and an in-order scoreboard for update commands.
module tb_branch_resolver;
  import bp_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        f_ready;
  logic        d_valid;
  logic        d_is_branch;
  logic        d_taken;
  logic [31:0] d_target;
  logic        d_ready;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_alloc;
  logic [15:0] mispredicts;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_resolver #(
    .QDEPTH (4),
    .UDEPTH (2),
    .CNTW   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .f_pred_taken  (f_pred_taken),
    .f_pred_target (f_pred_target),
    .f_ready       (f_ready),
    .d_valid       (d_valid),
    .d_is_branch   (d_is_branch),
    .d_taken       (d_taken),
    .d_target      (d_target),
    .d_ready       (d_ready),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .upd_alloc     (upd_alloc),
    .mispredicts   (mispredicts)
  );

  // ---------------- scoreboard ----------------
  logic [$bits(upd_cmd_t)-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_upd(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic al);
    upd_cmd_t e;
    e = '{pc: pc, target: tgt, taken: tk, alloc: al};
    exp_q.push_back(e);
  endtask

  // Any update accepted on the coming edge must be the oldest expected one.
  task automatic score_upd();
    upd_cmd_t e;
    if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("upd_unexpected", {31'd0, upd_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("upd_pc", upd_pc, e.pc);
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
        chk("upd_alloc", {31'd0, upd_alloc}, {31'd0, e.alloc});
        if (e.taken || e.alloc) begin
          chk("upd_target", upd_target, e.target);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; inputs change and outputs are checked 1 ns after the edge.
  task automatic step();
    score_upd();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    f_valid       = 1'b1;
    f_pc          = pc;
    f_pred_taken  = pt;
    f_pred_target = tgt;
    step();
    f_valid = 1'b0;
  endtask

  task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
    d_valid     = 1'b1;
    d_is_branch = br;
    d_taken     = tk;
    d_target    = tgt;
    step();
    d_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    f_valid       = 1'b0;
    f_pc          = '0;
    f_pred_taken  = 1'b0;
    f_pred_target = '0;
    d_valid       = 1'b0;
    d_is_branch   = 1'b0;
    d_taken       = 1'b0;
    d_target      = '0;
    upd_ready     = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // 1: reset then idle
    chk("t1_flush", {31'd0, flush}, 32'd0);
    chk("t1_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("t1_f_ready", {31'd0, f_ready}, 32'd1);
    chk("t1_d_ready", {31'd0, d_ready}, 32'd0);
    chk("t1_mispredicts", {16'd0, mispredicts}, 32'd0);
    chk("t1_redirect", redirect_pc, 32'd0);

    // 2: not predicted, resolved taken -> mispredict, alloc
    push(32'h10, 1'b0, 32'h14);
    chk("t2_d_ready", {31'd0, d_ready}, 32'd1);
    expect_upd(32'h10, 32'h20, 1'b1, 1'b1);
    resolve(1'b1, 1'b1, 32'h20);
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_redirect", redirect_pc, 32'h20);
    chk("t2_mispredicts", {16'd0, mispredicts}, 32'd1);
    chk("t2_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t2_d_ready_cleared", {31'd0, d_ready}, 32'd0);
    step();
    chk("t2_flush_pulse", {31'd0, flush}, 32'd0);
    chk("t2_upd_drained", {31'd0, upd_valid}, 32'd0);

    // 3: correct taken prediction
    push(32'h10, 1'b1, 32'h20);
    expect_upd(32'h10, 32'h20, 1'b1, 1'b0);
    resolve(1'b1, 1'b1, 32'h20);
    chk("t3_flush", {31'd0, flush}, 32'd0);
    chk("t3_mispredicts", {16'd0, mispredicts}, 32'd1);
    chk("t3_upd_valid", {31'd0, upd_valid}, 32'd1);
    step();
    chk("t3_upd_drained", {31'd0, upd_valid}, 32'd0);

    // 4: predicted taken, resolved not taken, with a same-cycle push
    push(32'h10, 1'b1, 32'h20);
    push(32'h20, 1'b0, 32'h24);
    f_valid       = 1'b1;
    f_pc          = 32'h24;
    f_pred_taken  = 1'b0;
    f_pred_target = 32'h28;
    expect_upd(32'h10, 32'h20, 1'b0, 1'b0);
    resolve(1'b1, 1'b0, 32'h24);
    chk("t4_flush", {31'd0, flush}, 32'd1);
    chk("t4_redirect", redirect_pc, 32'h14);
    chk("t4_queue_empty", {31'd0, d_ready}, 32'd0);
    chk("t4_f_ready", {31'd0, f_ready}, 32'd1);
    chk("t4_mispredicts", {16'd0, mispredicts}, 32'd2);
    // push offered during the flush cycle is wrong-path
    f_pc = 32'h30;
    step();
    f_valid = 1'b0;
    chk("t4_flush_pulse", {31'd0, flush}, 32'd0);
    chk("t4_push_in_flush_dropped", {31'd0, d_ready}, 32'd0);
    chk("t4_upd_drained", {31'd0, upd_valid}, 32'd0);

    // 5: update backpressure stalls the third resolve
    upd_ready = 1'b0;
    push(32'h40, 1'b1, 32'h140);
    push(32'h44, 1'b1, 32'h144);
    push(32'h48, 1'b1, 32'h148);
    expect_upd(32'h40, 32'h140, 1'b1, 1'b0);
    resolve(1'b1, 1'b1, 32'h140);
    expect_upd(32'h44, 32'h144, 1'b1, 1'b0);
    resolve(1'b1, 1'b1, 32'h144);
    d_valid     = 1'b1;
    d_is_branch = 1'b1;
    d_taken     = 1'b1;
    d_target    = 32'h148;
    chk("t5_stall", {31'd0, d_ready}, 32'd0);
    step();
    chk("t5_stall_held", {31'd0, d_ready}, 32'd0);
    upd_ready = 1'b1;
    step();
    chk("t5_unstall", {31'd0, d_ready}, 32'd1);
    expect_upd(32'h48, 32'h148, 1'b1, 1'b0);
    step();
    d_valid = 1'b0;
    chk("t5_queue_empty", {31'd0, d_ready}, 32'd0);
    step();
    step();
    chk("t5_upd_drained", {31'd0, upd_valid}, 32'd0);
    chk("t5_flush", {31'd0, flush}, 32'd0);
    chk("t5_mispredicts", {16'd0, mispredicts}, 32'd2);

    // 6: reset mid-operation with 2 queued and 1 pending update
    upd_ready = 1'b0;
    push(32'h60, 1'b1, 32'h70);
    push(32'h50, 1'b0, 32'h54);
    push(32'h54, 1'b0, 32'h58);
    resolve(1'b1, 1'b1, 32'h70);
    chk("t6_pending", {31'd0, upd_valid}, 32'd1);
    chk("t6_queued", {31'd0, d_ready}, 32'd1);
    reset = 1'b1;
    step();
    exp_q.delete();
    chk("t6_flush", {31'd0, flush}, 32'd0);
    chk("t6_redirect", redirect_pc, 32'd0);
    chk("t6_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("t6_d_ready", {31'd0, d_ready}, 32'd0);
    chk("t6_f_ready", {31'd0, f_ready}, 32'd1);
    chk("t6_mispredicts", {16'd0, mispredicts}, 32'd0);
    reset     = 1'b0;
    upd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_upd_after_reset", {31'd0, upd_valid}, 32'd0);
    end

    // 7: aliased non-branch at the top of the address space, pc+4 wraps to 0
    push(32'hFFFF_FFFC, 1'b1, 32'h100);
    expect_upd(32'hFFFF_FFFC, 32'h100, 1'b0, 1'b0);
    resolve(1'b0, 1'b0, 32'h0);
    chk("t7_flush", {31'd0, flush}, 32'd1);
    chk("t7_redirect_wrap", redirect_pc, 32'h0);
    chk("t7_mispredicts", {16'd0, mispredicts}, 32'd1);
    step();

    // 8: predicted taken to the wrong target -> redirect + alloc
    push(32'h80, 1'b1, 32'h90);
    expect_upd(32'h80, 32'hA0, 1'b1, 1'b1);
    resolve(1'b1, 1'b1, 32'hA0);
    chk("t8_flush", {31'd0, flush}, 32'd1);
    chk("t8_redirect", redirect_pc, 32'hA0);
    chk("t8_mispredicts", {16'd0, mispredicts}, 32'd2);
    step();

    // 9: not taken, not predicted -> no flush, no update
    push(32'h84, 1'b0, 32'h88);
    resolve(1'b1, 1'b0, 32'h50);
    chk("t9_flush", {31'd0, flush}, 32'd0);
    chk("t9_no_upd", {31'd0, upd_valid}, 32'd0);
    chk("t9_mispredicts", {16'd0, mispredicts}, 32'd2);
    step();
    chk("t9_exp_q_drained", exp_q.size(), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
